// File: rtl/elevator_call_panel.sv
// elevator_call_panel: synchronises, debounces and latches per-floor call
// buttons, clears a call when the door opens at its floor, and reports the
// floor that was served with a one-cycle pulse.
module elevator_call_panel #(
   parameter int NUM_FLOORS      = 5,
   parameter int FLOOR_W         = 3,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] btn_raw,
   input  logic [FLOOR_W-1:0]    current_floor,
   input  logic                  door_open,
   output logic [NUM_FLOORS-1:0] floor_request,
   output logic [NUM_FLOORS-1:0] call_lamp,
   output logic                  call_pending,
   output logic                  served_valid,
   output logic [FLOOR_W-1:0]    served_floor
);

   typedef enum logic {
      CALL_IDLE    = 1'b0,
      CALL_PENDING = 1'b1
   } call_state_e;

   // Counter value on which a mismatch has lasted DEBOUNCE_CYCLES cycles.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_FLOORS-1:0] sync1_q, sync1_d;
   logic [NUM_FLOORS-1:0] sync2_q, sync2_d;
   logic [NUM_FLOORS-1:0] stable_q, stable_d;
   logic [CNT_W-1:0]      cnt_q [NUM_FLOORS];
   logic [CNT_W-1:0]      cnt_d [NUM_FLOORS];
   logic [NUM_FLOORS-1:0] press;
   call_state_e           call_q [NUM_FLOORS];
   call_state_e           call_d [NUM_FLOORS];
   logic                  served_valid_q, served_valid_d;
   logic [FLOOR_W-1:0]    served_floor_q, served_floor_d;

   // Synchroniser feed and debounce: accept a level only after it has
   // differed from the stable value for DEBOUNCE_CYCLES consecutive cycles.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      sync1_d  = btn_raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
      // A press is the accepting edge of a 0->1 stable change; releases are ignored.
      press = stable_d & ~stable_q;
   end

   // Per-floor call FSM next state and served pulse: service beats a press.
   always_comb begin
      served_valid_d = 1'b0;
      served_floor_d = served_floor_q;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         call_d[i] = call_q[i];
         // An out-of-range current_floor matches no index and services nothing.
         if (door_open && (current_floor == FLOOR_W'(i))) begin
            call_d[i] = CALL_IDLE;
            if (call_q[i] == CALL_PENDING) begin
               served_valid_d = 1'b1;
               served_floor_d = FLOOR_W'(i);
            end
         end else if (press[i]) begin
            call_d[i] = CALL_PENDING;
         end
      end
   end

   // Request vector decoded from the registered call states.
   always_comb begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
         floor_request[i] = (call_q[i] == CALL_PENDING);
      end
   end

   assign call_lamp    = floor_request;
   assign call_pending = |floor_request;
   assign served_valid = served_valid_q;
   assign served_floor = served_floor_q;

   // State registers; reset drops every call and debounce state at once.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the values from before this edge.
      if (reset) begin
         sync1_q        <= '0;
         sync2_q        <= '0;
         stable_q       <= '0;
         served_valid_q <= 1'b0;
         served_floor_q <= '0;
         // NOTE: these per-floor arrays are a handful of flops, not a RAM,
         // so resetting every entry is cheap and required.
         for (int i = 0; i < NUM_FLOORS; i++) begin
            cnt_q[i]  <= '0;
            call_q[i] <= CALL_IDLE;
         end
      end else begin
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         stable_q       <= stable_d;
         served_valid_q <= served_valid_d;
         served_floor_q <= served_floor_d;
         for (int i = 0; i < NUM_FLOORS; i++) begin
            cnt_q[i]  <= cnt_d[i];
            call_q[i] <= call_d[i];
         end
      end
   end

endmodule

// File: tb/tb_elevator_call_panel.sv
// Testbench for elevator_call_panel: table of per-cycle stimulus rows with
// hand-derived expected outputs, checked through a scoreboard queue, plus a
// hand-written mid-operation reset sequence.
module tb_elevator_call_panel;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] btn_raw = '0;
   logic [2:0] current_floor = '0;
   logic       door_open = 1'b0;
   logic [4:0] floor_request;
   logic [4:0] call_lamp;
   logic       call_pending;
   logic       served_valid;
   logic [2:0] served_floor;

   elevator_call_panel #(
      .NUM_FLOORS(5),
      .FLOOR_W(3),
      .DEBOUNCE_CYCLES(4),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_raw(btn_raw),
      .current_floor(current_floor),
      .door_open(door_open),
      .floor_request(floor_request),
      .call_lamp(call_lamp),
      .call_pending(call_pending),
      .served_valid(served_valid),
      .served_floor(served_floor)
   );

   always #5 clk = ~clk;

   // One row = inputs driven before an edge and outputs expected after it.
   typedef struct {
      logic       rst;
      logic [4:0] btn;
      logic [2:0] fl;
      logic       door;
      logic [4:0] req;
      logic       sv;
      logic [2:0] sf;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // Append n identical rows; the reset flag applies to the first one only.
   task automatic add(input int n, input logic rst, input logic [4:0] btn, input logic [2:0] fl,
                      input logic door, input logic [4:0] req, input logic sv, input logic [2:0] sf);
      vec_t v;
      for (int k = 0; k < n; k++) begin
         v.rst  = rst && (k == 0);
         v.btn  = btn;
         v.fl   = fl;
         v.door = door;
         v.req  = req;
         v.sv   = sv;
         v.sf   = sf;
         vecs.push_back(v);
      end
   endtask

   // Assert reset away from the clock edge, confirm outputs clear at once,
   // then release on a falling edge so the next rising edge is edge 1.
   task automatic pulse_reset(input int idx);
      #2;
      reset = 1'b1;
      #1;
      check("reset floor_request", idx, floor_request, 5'b0);
      check("reset call_lamp", idx, call_lamp, 5'b0);
      check("reset call_pending", idx, call_pending, 1'b0);
      check("reset served_valid", idx, served_valid, 1'b0);
      check("reset served_floor", idx, served_floor, 3'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic apply_row(input int idx, input vec_t v);
      vec_t e;
      if (v.rst) pulse_reset(idx);
      btn_raw       = v.btn;
      current_floor = v.fl;
      door_open     = v.door;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("floor_request", idx, floor_request, e.req);
      check("call_lamp", idx, call_lamp, e.req);
      check("call_pending", idx, call_pending, |e.req);
      check("served_valid", idx, served_valid, e.sv);
      check("served_floor", idx, served_floor, e.sf);
   endtask

   initial begin
      // Press on floor 2 held from edge 1: request appears after edge 6.
      add(5, 1'b1, 5'b00100, 3'd0, 1'b0, 5'b00000, 1'b0, 3'd0);
      add(1, 1'b0, 5'b00100, 3'd0, 1'b0, 5'b00100, 1'b0, 3'd0);
      // Three-cycle glitch on floor 3, then bounce 1,0,1,1,1,1.
      add(3, 1'b1, 5'b01000, 3'd0, 1'b0, 5'b00000, 1'b0, 3'd0);
      add(3, 1'b0, 5'b00000, 3'd0, 1'b0, 5'b00000, 1'b0, 3'd0);
      add(1, 1'b0, 5'b01000, 3'd0, 1'b0, 5'b00000, 1'b0, 3'd0);
      add(1, 1'b0, 5'b00000, 3'd0, 1'b0, 5'b00000, 1'b0, 3'd0);
      add(5, 1'b0, 5'b01000, 3'd0, 1'b0, 5'b00000, 1'b0, 3'd0);
      add(1, 1'b0, 5'b01000, 3'd0, 1'b0, 5'b01000, 1'b0, 3'd0);
      // Floors 1 and 4 pending; door open at 4 for three cycles.
      add(5, 1'b1, 5'b10010, 3'd0, 1'b0, 5'b00000, 1'b0, 3'd0);
      add(1, 1'b0, 5'b10010, 3'd0, 1'b0, 5'b10010, 1'b0, 3'd0);
      add(1, 1'b0, 5'b00000, 3'd4, 1'b1, 5'b00010, 1'b1, 3'd4);
      add(2, 1'b0, 5'b00000, 3'd4, 1'b1, 5'b00010, 1'b0, 3'd4);
      add(1, 1'b0, 5'b00000, 3'd4, 1'b0, 5'b00010, 1'b0, 3'd4);
      // Press accepted while the door is open at floor 2: ignored; re-press after close sets.
      add(6, 1'b1, 5'b00100, 3'd2, 1'b1, 5'b00000, 1'b0, 3'd0);
      add(1, 1'b0, 5'b00000, 3'd2, 1'b1, 5'b00000, 1'b0, 3'd0);
      add(5, 1'b0, 5'b00000, 3'd2, 1'b0, 5'b00000, 1'b0, 3'd0);
      add(5, 1'b0, 5'b00100, 3'd2, 1'b0, 5'b00000, 1'b0, 3'd0);
      add(1, 1'b0, 5'b00100, 3'd2, 1'b0, 5'b00100, 1'b0, 3'd0);
      // All floors pending; out-of-range floors service nothing; floor 3 then clears alone.
      add(5, 1'b1, 5'b11111, 3'd0, 1'b0, 5'b00000, 1'b0, 3'd0);
      add(1, 1'b0, 5'b11111, 3'd0, 1'b0, 5'b11111, 1'b0, 3'd0);
      add(2, 1'b0, 5'b00000, 3'd5, 1'b1, 5'b11111, 1'b0, 3'd0);
      add(2, 1'b0, 5'b00000, 3'd7, 1'b1, 5'b11111, 1'b0, 3'd0);
      add(1, 1'b0, 5'b00000, 3'd3, 1'b1, 5'b10111, 1'b1, 3'd3);
      add(1, 1'b0, 5'b00000, 3'd3, 1'b0, 5'b10111, 1'b0, 3'd3);

      for (int i = 0; i < vecs.size(); i++) begin
         apply_row(i, vecs[i]);
      end

      // Mid-operation reset with floor 0 held: calls drop at once and
      // floor 0 re-latches six edges after reset releases.
      vecs.delete();
      add(5, 1'b1, 5'b01011, 3'd0, 1'b0, 5'b00000, 1'b0, 3'd0);
      add(1, 1'b0, 5'b01011, 3'd0, 1'b0, 5'b01011, 1'b0, 3'd0);
      add(2, 1'b0, 5'b00001, 3'd0, 1'b0, 5'b01011, 1'b0, 3'd0);
      add(5, 1'b1, 5'b00001, 3'd0, 1'b0, 5'b00000, 1'b0, 3'd0);
      add(1, 1'b0, 5'b00001, 3'd0, 1'b0, 5'b00001, 1'b0, 3'd0);
      for (int i = 0; i < vecs.size(); i++) begin
         apply_row(1000 + i, vecs[i]);
      end

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: %0d expected entries left, required 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time bound so the run always ends on its own.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/elevator_call_panel.md
Name: elevator_call_panel

Overview:
- Front end that generates `floor_request` for the elevator FSM from raw per-floor call buttons.
- Per button: synchronise, debounce, latch the press as a pending call and drive the button lamp.
- Clears a pending call when the controller reports the door open at that floor, and emits a one-cycle served pulse.
- Sits between the car/hall button panel and the elevator controller, and closes the request/service loop.

Parameters:
- NUM_FLOORS, 5, number of floors and width of all per-floor vectors.
- FLOOR_W, 3, width of `current_floor` and `served_floor`.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept a level change (minimum 1).
- CNT_W, 3, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- btn_raw  in  NUM_FLOORS  raw, asynchronous, bouncing call buttons (bit i = floor i)
- current_floor  in  FLOOR_W  floor reported by the controller
- door_open  in  1  controller door-open indication
- floor_request  out  NUM_FLOORS  registered pending-call vector to the controller
- call_lamp  out  NUM_FLOORS  button lamps; equal to `floor_request`
- call_pending  out  1  OR of `floor_request`
- served_valid  out  1  one-cycle pulse when a pending call is cleared
- served_floor  out  FLOOR_W  floor index of the cleared call; valid with `served_valid`, holds otherwise

Behaviour:
- Reset values (async): sync flops, stable levels, debounce counters, `floor_request`, `call_lamp`, `call_pending`, `served_valid` and `served_floor` all 0.
- Synchroniser: two flops per bit, s1 <= btn_raw, s2 <= s1. Only s2 is used downstream.
- Debounce, per bit:
  - If s2 == stable, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, stable <= s2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any mismatch shorter than DEBOUNCE_CYCLES cycles leaves stable unchanged.
- Press event: the accepting edge where stable goes 0->1. Release (1->0) never affects calls.
- Latency: raw rising before edge 1 and held gives `floor_request[i]` = 1 after edge 2+DEBOUNCE_CYCLES (edge 6 at default).
- Service condition for floor i: door_open == 1 and current_floor == i. A `current_floor` >= NUM_FLOORS services nothing.
- Per-floor call register (IDLE/PENDING):
  - IDLE -> PENDING on a press event while the service condition for that floor is false.
  - PENDING -> IDLE when the service condition holds.
  - PENDING plus a new press: stays PENDING (no double count).
- Simultaneous press and service on the same floor in the same cycle: service wins, the call stays IDLE, and no `served_valid` fires (nothing was pending).
- Press on floor i while the door is open at floor i: ignored.
- Served pulse: `served_valid` <= 1 and `served_floor` <= i on the edge where a PENDING bit clears. Otherwise `served_valid` <= 0.
  - At most one bit can clear per cycle, since `current_floor` is a single value.
  - Door held open several cycles: exactly one pulse, on the first cycle.
- Independence: other floors' calls are unaffected by service at floor i. Any number of floors may be pending at once.
- Outputs are registered. `call_pending` is computed from the registered vector; it may be a register or a combinational OR of registers.
- Reset mid-operation: all calls drop immediately.
  - A button held through reset re-registers 2+DEBOUNCE_CYCLES edges after reset deasserts, because stable restarts at 0.
- Nothing depends on moving direction. The controller owns scheduling; this block only latches and clears.

Test Plan:
- Reset, then btn_raw = 5'b00100 held from edge 1 -> `floor_request` = 5'b00100, `call_lamp` = 5'b00100 and `call_pending` = 1 after edge 6; remain 0 through edge 5.
- btn_raw[3] high for 3 cycles then low (glitch < DEBOUNCE_CYCLES); then bounce 1,0,1,1,1,1 -> no request from the glitch; request for bit 3 set only after 4 consecutive stable-high synced cycles.
- Pending 5'b10010, current_floor = 4, door_open = 1 for 3 cycles -> `floor_request` = 5'b00010 after one edge; `served_valid` pulses once with `served_floor` = 4.
- door_open = 1 at current_floor = 2 and btn_raw[2] accepted in that window -> bit 2 stays 0 and no `served_valid`; same press after door_open = 0 -> bit 2 sets.
- current_floor = 5 or 7 with door_open = 1 and all 5 floors pending -> `floor_request` stays 5'b11111 and no `served_valid`.
- Calls 5'b01011 pending with btn_raw[0] held, then reset pulsed mid-cycle -> all outputs 0 immediately; bit 0 re-latches at edge 2+DEBOUNCE_CYCLES after reset deasserts.
